// File: rtl/operand_collector_if.sv
// Operand collector bus bundle: dispatcher input, register-file read port and
// execution-unit output. The collector uses the slave modport, its environment
// (dispatcher, register file, execution units) uses the master modport.
interface operand_collector_if #(
    parameter int NumTags         = 8,
    parameter int PcWidth         = 32,
    parameter int WarpWidth       = 32,
    parameter int RegIdxWidth     = 6,
    parameter int OperandsPerInst = 2,
    parameter int RegWidth        = 32,
    parameter int InstWidth       = 32
);
    localparam int TagWidth = $clog2(NumTags);

    // Dispatcher side
    logic                                            opc_ready_o;
    logic                                            disp_valid_i;
    logic [TagWidth-1:0]                             disp_tag_i;
    logic [PcWidth-1:0]                              disp_pc_i;
    logic [WarpWidth-1:0]                            disp_act_mask_i;
    logic [InstWidth-1:0]                            disp_inst_i;
    logic [RegIdxWidth-1:0]                          disp_dst_i;
    logic [OperandsPerInst-1:0]                      disp_operands_required_i;
    logic [OperandsPerInst*RegIdxWidth-1:0]          disp_operands_i;

    // Register file read port
    logic                                            rf_req_valid_o;
    logic                                            rf_req_ready_i;
    logic [RegIdxWidth-1:0]                          rf_req_reg_o;
    logic                                            rf_rsp_valid_i;
    logic [WarpWidth*RegWidth-1:0]                   rf_rsp_data_i;

    // Execution unit side
    logic                                            eu_ready_i;
    logic                                            opc_valid_o;
    logic [TagWidth-1:0]                             opc_tag_o;
    logic [PcWidth-1:0]                              opc_pc_o;
    logic [WarpWidth-1:0]                            opc_act_mask_o;
    logic [InstWidth-1:0]                            opc_inst_o;
    logic [RegIdxWidth-1:0]                          opc_dst_o;
    logic [OperandsPerInst*WarpWidth*RegWidth-1:0]   opc_operand_data_o;

    modport slave (
        output opc_ready_o,
        input  disp_valid_i, disp_tag_i, disp_pc_i, disp_act_mask_i, disp_inst_i,
        input  disp_dst_i, disp_operands_required_i, disp_operands_i,
        output rf_req_valid_o, rf_req_reg_o,
        input  rf_req_ready_i, rf_rsp_valid_i, rf_rsp_data_i,
        input  eu_ready_i,
        output opc_valid_o, opc_tag_o, opc_pc_o, opc_act_mask_o, opc_inst_o,
        output opc_dst_o, opc_operand_data_o
    );

    modport master (
        input  opc_ready_o,
        output disp_valid_i, disp_tag_i, disp_pc_i, disp_act_mask_i, disp_inst_i,
        output disp_dst_i, disp_operands_required_i, disp_operands_i,
        input  rf_req_valid_o, rf_req_reg_o,
        output rf_req_ready_i, rf_rsp_valid_i, rf_rsp_data_i,
        output eu_ready_i,
        input  opc_valid_o, opc_tag_o, opc_pc_o, opc_act_mask_o, opc_inst_o,
        input  opc_dst_o, opc_operand_data_o
    );
endinterface

// File: rtl/operand_collector.sv
// Single-entry operand collector. Takes one instruction from the dispatcher,
// reads its required source operands from the register file one at a time
// (lowest operand slot first), then offers instruction plus data to the
// execution units. An issue handshake may coincide with the next accept, so
// back-to-back instructions see no idle bubble.
module operand_collector #(
    parameter int NumTags         = 8,
    parameter int PcWidth         = 32,
    parameter int WarpWidth       = 32,
    parameter int RegIdxWidth     = 6,
    parameter int OperandsPerInst = 2,
    parameter int RegWidth        = 32,
    parameter int InstWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    operand_collector_if.slave  bus
);
    localparam int TagWidth = $clog2(NumTags);
    localparam int DataW    = WarpWidth * RegWidth;
    localparam int KW       = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RSP   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t                       state_q;
    logic [OperandsPerInst-1:0]   pending_q;
    logic [KW-1:0]                cur_k_q;
    logic [TagWidth-1:0]          tag_q;
    logic [PcWidth-1:0]           pc_q;
    logic [WarpWidth-1:0]         act_mask_q;
    logic [InstWidth-1:0]         inst_q;
    logic [RegIdxWidth-1:0]       dst_q;
    logic [RegIdxWidth-1:0]       src_q   [OperandsPerInst];
    logic [DataW-1:0]             data_q  [OperandsPerInst];
    logic                         rf_req_valid_q;
    logic [RegIdxWidth-1:0]       rf_req_reg_q;
    logic                         opc_valid_q;

    logic [RegIdxWidth-1:0]       disp_src [OperandsPerInst];
    logic                         accept;
    logic [KW-1:0]                acc_k;
    logic [OperandsPerInst-1:0]   rem_pending_d;
    logic [KW-1:0]                next_k_d;

    // Index of the lowest set bit; operand 0 is always read before operand 1.
    function automatic logic [KW-1:0] lowest_idx(input logic [OperandsPerInst-1:0] m);
        logic [KW-1:0] idx;
        idx = '0;
        for (int k = OperandsPerInst - 1; k >= 0; k--) begin
            if (m[k]) idx = KW'(k);
        end
        return idx;
    endfunction

    // Unpack source indices and pack collected operand data, slot k = operand k.
    for (genvar gi = 0; gi < OperandsPerInst; gi++) begin : g_slot
        assign disp_src[gi] = bus.disp_operands_i[gi*RegIdxWidth +: RegIdxWidth];
        assign bus.opc_operand_data_o[gi*DataW +: DataW] = data_q[gi];
    end

    assign bus.opc_ready_o = (state_q == IDLE) || ((state_q == ISSUE) && bus.eu_ready_i);
    assign accept          = bus.disp_valid_i && bus.opc_ready_o;

    // Next read slot, both for a fresh instruction and after a response retires a slot.
    always_comb begin
        acc_k         = lowest_idx(bus.disp_operands_required_i);
        rem_pending_d = pending_q & ~(OperandsPerInst'(1) << cur_k_q);
        next_k_d      = lowest_idx(rem_pending_d);
    end

    // Collector FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            cur_k_q        <= '0;
            tag_q          <= '0;
            pc_q           <= '0;
            act_mask_q     <= '0;
            inst_q         <= '0;
            dst_q          <= '0;
            rf_req_valid_q <= 1'b0;
            rf_req_reg_q   <= '0;
            opc_valid_q    <= 1'b0;
            for (int k = 0; k < OperandsPerInst; k++) begin
                src_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else if (accept) begin
            // Accept is only possible in IDLE or on an issue handshake.
            tag_q      <= bus.disp_tag_i;
            pc_q       <= bus.disp_pc_i;
            act_mask_q <= bus.disp_act_mask_i;
            inst_q     <= bus.disp_inst_i;
            dst_q      <= bus.disp_dst_i;
            pending_q  <= bus.disp_operands_required_i;
            cur_k_q    <= acc_k;
            for (int k = 0; k < OperandsPerInst; k++) begin
                src_q[k]  <= disp_src[k];
                data_q[k] <= '0;
            end
            if (bus.disp_operands_required_i != '0) begin
                state_q        <= REQ;
                rf_req_valid_q <= 1'b1;
                rf_req_reg_q   <= disp_src[acc_k];
                opc_valid_q    <= 1'b0;
            end else begin
                state_q        <= ISSUE;
                rf_req_valid_q <= 1'b0;
                opc_valid_q    <= 1'b1;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.rf_req_ready_i) begin
                        rf_req_valid_q <= 1'b0;
                        state_q        <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rf_rsp_valid_i) begin
                        data_q[cur_k_q] <= bus.rf_rsp_data_i;
                        pending_q       <= rem_pending_d;
                        if (rem_pending_d != '0) begin
                            cur_k_q        <= next_k_d;
                            rf_req_valid_q <= 1'b1;
                            rf_req_reg_q   <= src_q[next_k_d];
                            state_q        <= REQ;
                        end else begin
                            opc_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.eu_ready_i) begin
                        opc_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_req_valid_o = rf_req_valid_q;
    assign bus.rf_req_reg_o   = rf_req_reg_q;
    assign bus.opc_valid_o    = opc_valid_q;
    assign bus.opc_tag_o      = tag_q;
    assign bus.opc_pc_o       = pc_q;
    assign bus.opc_act_mask_o = act_mask_q;
    assign bus.opc_inst_o     = inst_q;
    assign bus.opc_dst_o      = dst_q;

    // A response with no read outstanding is dropped; flag it in simulation.
    a_rsp_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.rf_rsp_valid_i && (state_q != RSP)))
        else $warning("rf_rsp_valid_i with no read outstanding; response ignored");

endmodule
